// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- general-purpose register file, two async read ports, one write
//
// Holds 2**ADDR_WIDTH registers x0..x(N-1) of DATA_WIDTH bits. Register x0 is
// hard-wired to zero: writes to it are dropped and it always reads as 0.
//
// Ports
//   clk               sole clock, all state updates on the rising edge
//   rst_n             synchronous active-low reset, clears every register
//   reg_write_enable  write strobe, sampled on the rising edge
//   write_addr        destination register index
//   write_data        data to store
//   read_addr1/2      read port indices
//   read_data1/2      combinational read data (no write-to-read bypass)
// ---------------------------------------------------------------------------
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Reset wins over a simultaneous write; x0 is never written, so after
    // the first reset its storage stays zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (reg_write_enable && (write_addr != '0)) begin
            regs[write_addr] <= write_data;
        end
    end

    // The explicit x0 decode keeps the zero read independent of storage.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (read_addr1 != '0) read_data1 = regs[read_addr1];
        if (read_addr2 != '0) read_data2 = regs[read_addr2];
    end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .reg_write_enable (reg_write_enable),
        .write_addr       (write_addr),
        .write_data       (write_data),
        .read_addr1       (read_addr1),
        .read_addr2       (read_addr2),
        .read_data1       (read_data1),
        .read_data2       (read_data2)
    );

    always #5 clk = ~clk;

    // Reference: a plain array of 32 words; x0 reads as zero by rule.
    logic [31:0] model [32];

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    typedef struct {
        string       name;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    // Monitor: read ports are always presenting data; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (read_data1 !== e.e1) begin
                failed++;
                $display("FAIL %s port1 addr=%0d got=%h exp=%h", e.name, e.a1, read_data1, e.e1);
            end
            tests++;
            if (read_data2 !== e.e2) begin
                failed++;
                $display("FAIL %s port2 addr=%0d got=%h exp=%h", e.name, e.a2, read_data2, e.e2);
            end
        end
    end

    // One clock cycle: drive inputs, queue the pre-edge expectation, then
    // apply the specification's update rule to the model at the edge.
    task automatic step(input logic r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1,
                        input logic [4:0] a2, input string nm, input bit chk);
        exp_t e;
        rst_n            = r;
        reg_write_enable = we;
        write_addr       = wa;
        write_data       = wd;
        read_addr1       = a1;
        read_addr2       = a2;
        if (chk) begin
            e.name = nm; e.a1 = a1; e.a2 = a2;
            e.e1 = model_read(a1);
            e.e2 = model_read(a2);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
        #1;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input string nm);
        step(1'b1, 1'b0, 5'd0, 32'd0, a1, a2, nm, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'hx;

        // Reset with a concurrent write; outputs undefined before first edge.
        step(1'b0, 1'b1, 5'd3, 32'h1111_1111, 5'd0, 5'd3, "rst0", 1'b0);
        step(1'b0, 1'b1, 5'd3, 32'h2222_2222, 5'd3, 5'd0, "rst_hold", 1'b1);
        // Write honoured in the first cycle after deassertion.
        step(1'b1, 1'b1, 5'd1, 32'hDEAD_BEEF, 5'd1, 5'd0, "x1_wr", 1'b1);
        rd(5'd1, 5'd0, "x1_rd");
        step(1'b1, 1'b1, 5'd0, 32'hCAFE_CAFE, 5'd0, 5'd1, "x0_wr", 1'b1);
        rd(5'd0, 5'd1, "x0_rd");
        step(1'b1, 1'b1, 5'd5, 32'h1234_5678, 5'd1, 5'd5, "x5_wr", 1'b1);
        rd(5'd1, 5'd5, "x5_rd");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd1, "we_low", 1'b1);
        rd(5'd5, 5'd5, "we_low_after");

        // Reset beats a write of x5; every address reads zero afterwards.
        step(1'b0, 1'b1, 5'd5, 32'hAAAA_AAAA, 5'd1, 5'd5, "rst_vs_wr", 1'b1);
        for (int i = 0; i < 16; i++)
            rd(5'(2 * i), 5'(2 * i + 1), "post_rst_sweep");

        // Same-address read on both ports across a write of x31.
        step(1'b1, 1'b1, 5'd31, 32'h0000_FFFF, 5'd31, 5'd31, "x31_old", 1'b1);
        rd(5'd31, 5'd31, "x31_new");
        step(1'b1, 1'b1, 5'd31, 32'h8000_0001, 5'd31, 5'd31, "x31_old2", 1'b1);
        rd(5'd31, 5'd31, "x31_new2");

        // Randomised traffic, biased toward x0/x31 and an occasional reset.
        for (int n = 0; n < 400; n++) begin
            logic        r, we;
            logic [4:0]  wa, a1, a2;
            logic [31:0] wd;
            r  = ($urandom_range(0, 49) != 0);
            we = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       wa = 5'd0;
                1:       wa = 5'd31;
                default: wa = 5'($urandom_range(0, 31));
            endcase
            wd = $urandom();
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 4) == 0) ? a1 : 5'($urandom_range(0, 31));
            step(r, we, wa, wd, a1, a2, "random", 1'b1);
        end

        // Final read-back of every register.
        for (int i = 0; i < 32; i++)
            rd(5'(i), 5'(31 - i), "final_sweep");

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached sim time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5: register index width, giving 2**ADDR_WIDTH registers (32 by default).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 reg_write_enable  input  1  write strobe; a write occurs on a rising edge while high.
REQ-006 write_addr  input  ADDR_WIDTH  destination register index.
REQ-007 write_data  input  DATA_WIDTH  data to store.
REQ-008 read_addr1  input  ADDR_WIDTH  index for read port 1.
REQ-009 read_addr2  input  ADDR_WIDTH  index for read port 2.
REQ-010 read_data1  output  DATA_WIDTH  contents of register read_addr1.
REQ-011 read_data2  output  DATA_WIDTH  contents of register read_addr2.

Function
REQ-012 The block SHALL hold 2**ADDR_WIDTH registers x0..x(N-1), each DATA_WIDTH bits.
REQ-013 Register x0 SHALL always read as 0.
REQ-014 Writes to x0 SHALL be discarded, with no state change.
REQ-015 On a rising edge with rst_n=1, reg_write_enable=1 and write_addr!=0, the register at write_addr SHALL take write_data.
REQ-016 When a write completes, no other register SHALL change.
REQ-017 With reg_write_enable=0, no register SHALL change.
REQ-018 Both read ports SHALL be combinational and asynchronous: read_dataN reflects the register at read_addrN within the same cycle, with zero clock latency.
REQ-019 There SHALL be no write-to-read bypass. A read of the register being written returns the old value until the rising edge, then the new value.
REQ-020 Both ports MAY address the same register simultaneously; both SHALL return identical data.
REQ-021 The outputs SHALL never be X/Z once reset has been applied at least once.

Reset
REQ-022 On a rising edge with rst_n=0, every register SHALL clear to 0.
REQ-023 Reset SHALL take priority over a simultaneous write; the write is dropped.
REQ-024 During and after reset, read_data1 and read_data2 SHALL be 0 for every address until a subsequent write.
REQ-025 Deassertion of rst_n SHALL take effect at the next rising edge, with no extra idle cycles; a write in the first cycle after deassertion SHALL be honoured.

Verification
REQ-026 Write x1 := 0xDEADBEEF, read_addr1=1, read_addr2=0 -> after the edge, read_data1=0xDEADBEEF and read_data2=0x00000000.
REQ-027 Write x0 := 0xCAFECAFE, read_addr1=0, read_addr2=1 -> read_data1=0x00000000 and read_data2=0xDEADBEEF (x1 is unchanged).
REQ-028 Write x5 := 0x12345678, read_addr1=1, read_addr2=5 -> read_data1=0xDEADBEEF and read_data2=0x12345678.
REQ-029 Set write_addr=5, write_data=0xFFFFFFFF with reg_write_enable=0 for several edges -> x5 remains 0x12345678.
REQ-030 With x1 and x5 nonzero, hold rst_n=0 together with a write of x5 := 0xAAAAAAAA for one edge -> x1, x5 and all 32 addresses read 0; the write is lost.
REQ-031 Write x31 := 0x0000FFFF and read it on both ports in the same cycle -> both ports show the old value before the edge and 0x0000FFFF after it.
